// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: degree-scaled atan table (deg*2^16), angle constants, gain and FSM state encoding.
package cordic_pkg;

  localparam int DEG90  = 5898240;
  localparam int DEG180 = 11796480;
  localparam int DEG360 = 23592960;
  localparam int K_GAIN = 39797;

  // atan(2^-i) in degrees * 2^16, rounded to nearest
  localparam logic signed [31:0] ATAN_TAB [0:15] = '{
    32'sd2949120, 32'sd1740967, 32'sd919879, 32'sd466945,
    32'sd234379,  32'sd117304,  32'sd58666,  32'sd29335,
    32'sd14668,   32'sd7334,    32'sd3667,   32'sd1833,
    32'sd917,     32'sd458,     32'sd229,    32'sd115
  };

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    PRE   = 5'b00010,
    WORK  = 5'b00100,
    SCALE = 5'b01000,
    DONE  = 5'b10000
  } vec_state_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the rotated angle in z.
// Purely combinational; the top reuses one instance once per iteration.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  logic signed [31:0] z,
  input  logic        [3:0]  cnt,
  output logic signed [31:0] x_next,
  output logic signed [31:0] y_next,
  output logic signed [31:0] z_next
);

  logic signed [31:0] x_sh;
  logic signed [31:0] y_sh;

  always_comb begin
    x_sh = x >>> cnt;
    y_sh = y >>> cnt;
    if (!y[31]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + ATAN_TAB[cnt];
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - ATAN_TAB[cnt];
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: (x,y) -> magnitude Q24.8 and phase deg*2^16 in [0,360).
// Accept to out_valid is ITER+3 clocks; in_ready only while idle, inputs ignored while busy.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITER   = 16,
  parameter int K_GAIN = cordic_pkg::K_GAIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               out_valid,
  output logic        [31:0] mag_out,
  output logic        [31:0] phase_out
);

  vec_state_t         state;
  logic signed [31:0] x, y, z;
  logic signed [31:0] x_n, y_n, z_n;
  logic        [3:0]  cnt;
  logic               zero_flag;
  logic signed [47:0] x_ext, k_ext, prod;
  logic signed [31:0] phase_wrap;
  logic        [31:0] mag_scaled;

  cordic_vec_stage u_stage (
    .x      (x),
    .y      (y),
    .z      (z),
    .cnt    (cnt),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  always_comb begin
    x_ext      = {{16{x[31]}}, x};
    k_ext      = 48'(K_GAIN);
    prod       = x_ext * k_ext;
    mag_scaled = 32'(prod >>> 16);
    phase_wrap = z;
    if (z < 0)
      phase_wrap = z + DEG360;
    else if (z >= DEG360)
      phase_wrap = z - DEG360;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
      mag_out   <= '0;
      phase_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= {{8{x_in[15]}}, x_in, 8'h00};
            y     <= {{8{y_in[15]}}, y_in, 8'h00};
            state <= PRE;
          end
        end
        PRE: begin
          // fold the left half-plane onto the right; the 180 deg offset restores it
          if (x[31]) begin
            x <= -x;
            y <= -y;
            z <= DEG180;
          end else begin
            z <= '0;
          end
          zero_flag <= (x == 0) && (y == 0);
          cnt       <= '0;
          state     <= WORK;
        end
        WORK: begin
          x   <= x_n;
          y   <= y_n;
          z   <= z_n;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(ITER - 1))
            state <= SCALE;
        end
        SCALE: begin
          mag_out   <= zero_flag ? 32'd0 : mag_scaled;
          phase_out <= zero_flag ? 32'd0 : 32'(phase_wrap);
          state     <= DONE;
        end
        DONE: begin
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed, random and back-to-back vectors against a real-arithmetic atan2/sqrt model.
module tb_cordic_vector;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic               out_valid;
  logic        [31:0] mag_out;
  logic        [31:0] phase_out;

  int checks = 0;
  int errors = 0;

  localparam real PI    = 3.14159265358979;
  localparam real R360  = 23592960.0;
  localparam int  LAT   = 19;

  cordic_vector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .mag_out   (mag_out),
    .phase_out (phase_out)
  );

  always #5 clk = ~clk;

  function automatic real ref_mag(input int x, input int y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * 256.0;
  endfunction

  function automatic real ref_phase(input int x, input int y);
    real p;
    if (x == 0 && y == 0) return 0.0;
    p = $atan2(real'(y), real'(x)) * 180.0 / PI * 65536.0;
    if (p < 0.0) p = p + R360;
    return p;
  endfunction

  function automatic real mag_err(input logic [31:0] m, input real r);
    real d;
    d = real'(m) - r;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic real mag_tol(input real r);
    return r * 0.001 + 2.0;
  endfunction

  // circular distance, but only for values already inside [0,360)
  function automatic real phase_err(input logic [31:0] p, input real r);
    real d;
    d = real'(p) - r;
    if (d < 0.0) d = -d;
    if (d > R360 / 2.0 && real'(p) < R360) d = R360 - d;
    return d;
  endfunction

  function automatic int rand_coord();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic run_op(input int x, input int y, output logic [31:0] m,
                        output logic [31:0] p, output int lat);
    lat = -1;
    @(negedge clk);
    x_in     = 16'(x);
    y_in     = 16'(y);
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    m = mag_out;
    p = phase_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (mag_out !== 32'd0) begin errors++; $display("FAIL reset_mag got %0d want 0", mag_out); end
    checks++;
    if (phase_out !== 32'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int dx [9] = '{1000, 0, -1000, 0, -1000, -32768, 1000, 32767, -20000};
    int dy [9] = '{0, 1000, -1000, 0, 0, -32768, -3, -32768, 15000};
    logic [31:0] m, p;
    int lat;
    real rm, rp;
    for (int i = 0; i < 9; i++) begin
      run_op(dx[i], dy[i], m, p, lat);
      rm = ref_mag(dx[i], dy[i]);
      rp = ref_phase(dx[i], dy[i]);
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      checks++;
      if (dx[i] == 0 && dy[i] == 0) begin
        if (m !== 32'd0 || p !== 32'd0) begin
          errors++; $display("FAIL dir%0d_zero got mag %0d phase %0d want 0 0", i, m, p);
        end
      end else if (mag_err(m, rm) > mag_tol(rm) || phase_err(p, rp) > 656.0) begin
        errors++;
        $display("FAIL dir%0d_value (%0d,%0d) got mag %0d phase %0d want mag %0.1f phase %0.1f",
                 i, dx[i], dy[i], m, p, rm, rp);
      end
      checks++;
      if (p >= 32'd23592960) begin errors++; $display("FAIL dir%0d_range got phase %0d want < 23592960", i, p); end
    end
  endtask

  task automatic test_random();
    logic [31:0] m, p;
    int lat, x, y;
    real rm, rp;
    for (int i = 0; i < 30; i++) begin
      x = rand_coord();
      y = rand_coord();
      if (x > -600 && x < 600 && y > -600 && y < 600) x = 20000;
      run_op(x, y, m, p, lat);
      rm = ref_mag(x, y);
      rp = ref_phase(x, y);
      checks++;
      if (lat != LAT || mag_err(m, rm) > mag_tol(rm) || phase_err(p, rp) > 656.0 || p >= 32'd23592960) begin
        errors++;
        $display("FAIL rand%0d (%0d,%0d) got lat %0d mag %0d phase %0d want lat %0d mag %0.1f phase %0.1f",
                 i, x, y, lat, m, p, LAT, rm, rp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int qx[$], qy[$], qc[$];
    int last_acc = -1;
    int nout = 0;
    int ex, ey, ec;
    real rm, rp;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in = 16'(rand_coord());
      y_in = 16'(rand_coord());
      if (x_in > -600 && x_in < 600) x_in = 16'sd12345;
      if (in_ready) begin
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != LAT + 1) begin
            errors++; $display("FAIL b2b_spacing got %0d want %0d", c - last_acc, LAT + 1);
          end
        end
        last_acc = c;
        qx.push_back(int'(x_in));
        qy.push_back(int'(y_in));
        qc.push_back(c);
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        nout++;
        checks++;
        if (qc.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_out got out_valid at %0d want none", c);
        end else begin
          ex = qx.pop_front();
          ey = qy.pop_front();
          ec = qc.pop_front();
          rm = ref_mag(ex, ey);
          rp = ref_phase(ex, ey);
          if (c - ec != LAT || mag_err(mag_out, rm) > mag_tol(rm) || phase_err(phase_out, rp) > 656.0) begin
            errors++;
            $display("FAIL b2b_result (%0d,%0d) got lat %0d mag %0d phase %0d want lat %0d mag %0.1f phase %0.1f",
                     ex, ey, c - ec, mag_out, phase_out, LAT, rm, rp);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 4) begin errors++; $display("FAIL b2b_count got %0d outputs want 4", nout); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] m, p;
    int lat, seen;
    real rm, rp;
    run_op(3000, 4000, m, p, lat);
    @(negedge clk);
    x_in = 16'sd5000;
    y_in = 16'sd7000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mag_out !== 32'd0 || phase_out !== 32'd0) begin
      errors++; $display("FAIL midreset_outputs got mag %0d phase %0d want 0 0", mag_out, phase_out);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_no_output got %0d pulses want 0", seen); end
    run_op(-1000, 1000, m, p, lat);
    rm = ref_mag(-1000, 1000);
    rp = ref_phase(-1000, 1000);
    checks++;
    if (lat != LAT || mag_err(m, rm) > mag_tol(rm) || phase_err(p, rp) > 656.0) begin
      errors++;
      $display("FAIL midreset_next got lat %0d mag %0d phase %0d want lat %0d mag %0.1f phase %0.1f",
               lat, m, p, LAT, rm, rp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
